fir_err_capture: RTL and testbench

- Sink for the adaptive FIR error stream (o_data of fir_adaptive).
- Captures a programmable-length frame of signed samples into an internal buffer, then drains it in order over a valid/ready stream for readback and comparison against reference vectors.
- Sits after fir_adaptive in the datapath and replaces file-based output dumping.

---
 rtl/fir_err_capture.sv | 166 ++++++++++++++++
 tb/tb_fir_err_capture.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fir_err_capture.sv
// fir_err_capture: frame capture buffer for the adaptive FIR error stream.
// Arms on i_start in IDLE, writes i_len (0 = full depth) qualified samples into
// an internal buffer, then drains them in order on a valid/ready stream.
//
// Optional build macro: FIR_CAPTURE_PEAK_EN adds a running max |sample| tracker
// on o_peak (saturating abs). Without it, o_peak is tied to 0.
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_start, i_len          arm pulse and frame length (IDLE only)
//   i_valid, i_data         input sample stream (CAPTURE only)
//   o_data, o_valid, o_last drained sample stream
//   i_ready                 downstream accept
//   o_busy, o_done          CAPTURE/DRAIN flag, end-of-frame pulse
//   o_count                 samples written in the current frame
//   o_peak                  max |sample| of the frame
module fir_err_capture #(
  parameter int NB_DATA  = 32,
  parameter int NB_DEPTH = 15
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [NB_DEPTH-1:0] i_len,
  input  logic                i_valid,
  input  logic [NB_DATA-1:0]  i_data,
  output logic [NB_DATA-1:0]  o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_last,
  output logic                o_busy,
  output logic                o_done,
  output logic [NB_DEPTH:0]   o_count,
  output logic [NB_DATA-1:0]  o_peak
);

  localparam int DEPTH = 1 << NB_DEPTH;
  localparam logic [NB_DEPTH:0]   FULL_LEN = {1'b1, {NB_DEPTH{1'b0}}};
  localparam logic [NB_DEPTH:0]   ONE_C    = {{NB_DEPTH{1'b0}}, 1'b1};
  localparam logic [NB_DEPTH-1:0] ONE_P    = {{(NB_DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t state_q, state_d;

  logic [NB_DEPTH:0]   len_q, count_q, rd_ptr_q;
  logic [NB_DEPTH-1:0] wr_ptr_q;
  logic [NB_DATA-1:0]  mem [DEPTH];
  logic [NB_DATA-1:0]  rd_data_q, data_q;
  // [0] = prefetch (RAM read) stage, [1] = output register stage
  logic [1:0]          vld_pipe_q;
  logic                s1_last_q, last_q, done_q;

  logic start_go, wr_en, wr_last, xfer, xfer_last, out_load, pf_load;
  logic [NB_DEPTH:0] count_inc, rd_inc;

  assign count_inc = count_q + ONE_C;
  assign rd_inc    = rd_ptr_q + ONE_C;
  assign start_go  = (state_q == IDLE) && i_start;
  assign wr_en     = (state_q == CAPTURE) && i_valid;
  assign wr_last   = wr_en && (count_inc == len_q);
  assign xfer      = vld_pipe_q[1] && i_ready;
  assign xfer_last = xfer && last_q;
  // Output register refills whenever it is empty or being accepted this cycle.
  assign out_load  = vld_pipe_q[0] && (!vld_pipe_q[1] || i_ready);
  // Prefetch keeps one sample in flight so a held-high ready sees no bubbles.
  assign pf_load   = (state_q == DRAIN) && (rd_ptr_q != len_q) &&
                     (!vld_pipe_q[0] || out_load);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start)   state_d = CAPTURE;
      CAPTURE: if (wr_last)   state_d = DRAIN;
      DRAIN:   if (xfer_last) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Buffer and its read port are not reset; contents are don't-care after reset.
  always_ff @(posedge i_clk) begin
    if (wr_en)   mem[wr_ptr_q] <= i_data;
    if (pf_load) rd_data_q     <= mem[rd_ptr_q[NB_DEPTH-1:0]];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_q      <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      vld_pipe_q <= '0;
      s1_last_q  <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= xfer_last;
      if (start_go) begin
        len_q      <= (i_len == '0) ? FULL_LEN : {1'b0, i_len};
        count_q    <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        vld_pipe_q <= '0;
      end
      if (wr_en) begin
        // Full-depth frame wraps wr_ptr to 0 on the final write.
        wr_ptr_q <= wr_ptr_q + ONE_P;
        count_q  <= count_inc;
      end
      if (pf_load) begin
        vld_pipe_q[0] <= 1'b1;
        s1_last_q     <= (rd_inc == len_q);
        rd_ptr_q      <= rd_inc;
      end else if (out_load) begin
        vld_pipe_q[0] <= 1'b0;
      end
      if (out_load) begin
        vld_pipe_q[1] <= 1'b1;
        data_q        <= rd_data_q;
        last_q        <= s1_last_q;
      end else if (xfer) begin
        vld_pipe_q[1] <= 1'b0;
        last_q        <= 1'b0;
      end
    end
  end

  assign o_data  = data_q;
  assign o_valid = vld_pipe_q[1];
  assign o_last  = last_q;
  assign o_busy  = (state_q != IDLE);
  assign o_done  = done_q;
  assign o_count = count_q;

`ifdef FIR_CAPTURE_PEAK_EN
  localparam logic [NB_DATA-1:0] MIN_NEG = {1'b1, {(NB_DATA-1){1'b0}}};
  localparam logic [NB_DATA-1:0] MAX_POS = {1'b0, {(NB_DATA-1){1'b1}}};
  localparam logic [NB_DATA-1:0] ONE_D   = {{(NB_DATA-1){1'b0}}, 1'b1};

  logic [NB_DATA-1:0] mag, peak_q;

  // |x| with the most negative value saturated so it stays representable.
  always_comb begin
    mag = i_data;
    if (i_data[NB_DATA-1])
      mag = (i_data == MIN_NEG) ? MAX_POS : (~i_data) + ONE_D;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  peak_q <= '0;
    else if (start_go)             peak_q <= '0;
    else if (wr_en && mag > peak_q) peak_q <= mag;
  end

  assign o_peak = peak_q;
`else
  assign o_peak = '0;
`endif

endmodule

// File: tb/tb_fir_err_capture.sv
module tb_fir_err_capture;
  localparam int NB_DATA  = 32;
  localparam int NB_DEPTH = 4;
`ifdef FIR_CAPTURE_PEAK_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  logic                i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0;
  logic                i_valid = 1'b0, i_ready = 1'b0;
  logic [NB_DEPTH-1:0] i_len = '0;
  logic [NB_DATA-1:0]  i_data = '0;
  logic [NB_DATA-1:0]  o_data, o_peak;
  logic                o_valid, o_last, o_busy, o_done;
  logic [NB_DEPTH:0]   o_count;

  fir_err_capture #(.NB_DATA(NB_DATA), .NB_DEPTH(NB_DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_len(i_len),
    .i_valid(i_valid), .i_data(i_data), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_last(o_last), .o_busy(o_busy), .o_done(o_done),
    .o_count(o_count), .o_peak(o_peak)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_err = 0;
  logic [31:0] dir_q[$];
  bit          val_pat[$], rdy_pat[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] abs_sat(input logic [31:0] v);
    if (v == 32'h8000_0000) return 32'h7fff_ffff;
    if (v[31]) return -v;
    return v;
  endfunction

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  // One full frame: reference is a FIFO of the samples the spec says get captured.
  task automatic frame(input int len, input int vprob, input int rprob, input int abort_at);
    logic [31:0] exp_q[$];
    logic [31:0] peak, d;
    int n, guard, acc;
    bit v, r, always_rdy, take;
    exp_q = {}; peak = '0; n = 0; acc = 0;
    always_rdy = (rprob >= 100) && (rdy_pat.size() == 0);
    // i_valid in IDLE must not write
    i_valid = 1'b1; i_data = 32'h1234; step();
    chk("idle_busy", o_busy, 0);
    i_len = len[NB_DEPTH-1:0]; i_start = 1'b1; i_valid = 1'b0; step();
    i_start = 1'b0;
    chk("start_busy", o_busy, 1); chk("start_cnt", o_count, 0); chk("start_peak", o_peak, 0);
    guard = 0;
    while (n < len && guard < 400) begin
      v = (val_pat.size() != 0) ? val_pat.pop_front() : ($urandom_range(99) < vprob);
      if (v && dir_q.size() != 0) d = dir_q.pop_front();
      else d = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom();
      i_valid = v; i_data = d;
      i_start = ($urandom_range(7) == 0); i_len = NB_DEPTH'($urandom());
      step(); guard++;
      if (v) begin
        exp_q.push_back(d); n++;
        if (abs_sat(d) > peak) peak = abs_sat(d);
      end
      chk("cnt", o_count, n);
      chk("peak", o_peak, PEAK ? peak : 32'h0);
      chk("cap_vld", o_valid, 0);
    end
    if (n < len) begin
      chk("cap_timeout", n, len);
      return;
    end
    i_start = 1'b0; i_valid = 1'b1; i_data = $urandom(); i_ready = 1'b0;  // dropped write
    step();
    chk("lat1_vld", o_valid, 0); chk("drop_cnt", o_count, len); chk("drain_busy", o_busy, 1);
    i_valid = 1'b0;
    step();
    chk("lat2_vld", o_valid, 1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      r = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : ($urandom_range(99) < rprob);
      i_ready = r; take = 1'b0;
      if (o_valid) begin
        chk("data", o_data, exp_q[0]);
        chk("last", o_last, exp_q.size() == 1);
        take = r;
      end else if (always_rdy) begin
        chk("bubble", o_valid, 1);
      end
      step(); guard++;
      if (take) begin
        void'(exp_q.pop_front()); acc++;
        if (acc == abort_at) begin
          #2 i_rst_n = 1'b0;
          #1;
          chk("abort_vld", o_valid, 0); chk("abort_busy", o_busy, 0);
          chk("abort_cnt", o_count, 0); chk("abort_last", o_last, 0);
          chk("abort_done", o_done, 0);
          @(negedge i_clk); i_rst_n = 1'b1; i_ready = 1'b0;
          rdy_pat = {}; val_pat = {}; dir_q = {};
          step();
          return;
        end
      end
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    chk("end_vld", o_valid, 0); chk("end_last", o_last, 0); chk("done", o_done, 1);
    chk("end_busy", o_busy, 0); chk("end_cnt", o_count, len);
    i_ready = 1'b0;
    step();
    chk("done_pulse", o_done, 0); chk("hold_cnt", o_count, len);
    chk("hold_peak", o_peak, PEAK ? peak : 32'h0);
  endtask

  initial begin
    step(); step();
    chk("rst_vld", o_valid, 0); chk("rst_busy", o_busy, 0); chk("rst_done", o_done, 0);
    chk("rst_last", o_last, 0); chk("rst_cnt", o_count, 0); chk("rst_data", o_data, 0);
    chk("rst_peak", o_peak, 0);
    @(negedge i_clk); i_rst_n = 1'b1;
    step();

    // basic: 5,-3,7,0 with continuous valid and ready
    dir_q = {32'd5, -32'sd3, 32'd7, 32'd0}; val_pat = {1, 1, 1, 1};
    frame(4, 100, 100, -1);
    // backpressure pattern
    dir_q = {32'd1, 32'd2, 32'd3}; val_pat = {1, 1, 1}; rdy_pat = {0, 1, 0, 0, 1, 1};
    frame(3, 100, 50, -1);
    // gapped valid
    dir_q = {32'd9, 32'd10}; val_pat = {1, 0, 0, 1};
    frame(2, 100, 100, -1);
    // full depth via len=0 encoding, then again with random gaps/backpressure
    frame(16, 100, 100, -1);
    frame(16, 60, 60, -1);
    // reset mid-drain after 2 of 5 accepted, then a normal single-sample frame
    frame(5, 100, 100, 2);
    frame(1, 100, 100, -1);
    // peak sequence 3,8,sat,sat
    dir_q = {32'd3, -32'sd8, 32'h8000_0000, 32'd2}; val_pat = {1, 1, 1, 1};
    frame(4, 100, 100, -1);
    for (int k = 0; k < 8; k++)
      frame($urandom_range(16, 1), $urandom_range(100, 30), $urandom_range(100, 30), -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
